// File: rtl/bram_dp_be.sv
// Simple-dual-port block RAM: one write port with per-byte enables, one read port, single clock.
// Selectable read-during-write, optional output register, read-valid and out-of-range flags.
module bram_dp_be #(
    parameter int ADDR_WIDTH = 12,
    parameter int DEPTH      = 11,
    parameter int BIT_WIDTH  = 32,
    parameter int OUT_REG    = 0,
    parameter int RDW_MODE   = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [BIT_WIDTH/8-1:0] we,
    input  logic [ADDR_WIDTH-1:0]  waddr,
    input  logic [BIT_WIDTH-1:0]   wdi,
    input  logic                   re,
    input  logic [ADDR_WIDTH-1:0]  raddr,
    output logic [BIT_WIDTH-1:0]   rdo,
    output logic                   rvalid,
    output logic                   werr,
    output logic                   rerr
);

    localparam int NB = BIT_WIDTH / 8;
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);

    if (BIT_WIDTH % 8 != 0) begin : g_bad_width
        $error("bram_dp_be: BIT_WIDTH must be a multiple of 8");
    end

    logic [BIT_WIDTH-1:0] mem [DEPTH];

    logic          w_inrange;
    logic          r_inrange;
    logic          wr_ok;
    logic [IW-1:0] widx;
    logic [IW-1:0] ridx;
    logic [BIT_WIDTH-1:0] rd_word;

    assign w_inrange = {1'b0, waddr} < DEPTH_L;
    assign r_inrange = {1'b0, raddr} < DEPTH_L;
    assign wr_ok     = (|we) && w_inrange;
    assign widx      = waddr[IW-1:0];
    assign ridx      = raddr[IW-1:0];

    // NOTE: the array carries no reset; a reset would prevent block-RAM inference.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            for (int i = 0; i < NB; i++) begin
                if (we[i]) mem[widx][8*i +: 8] <= wdi[8*i +: 8];
            end
        end
    end

    // Write-first forwards the enabled bytes of the colliding write.
    // NOTE: rd_word gets its default first so no path leaves it unassigned (no latch).
    always_comb begin
        rd_word = mem[ridx];
        if (RDW_MODE != 0 && wr_ok && raddr == waddr) begin
            for (int i = 0; i < NB; i++) begin
                if (we[i]) rd_word[8*i +: 8] = wdi[8*i +: 8];
            end
        end
        if (!r_inrange) rd_word = '0;
    end

    logic                 s1_valid;
    logic                 s1_err;
    logic [BIT_WIDTH-1:0] s1_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_err   <= 1'b0;
            werr     <= 1'b0;
        end else begin
            s1_valid <= re;
            s1_err   <= re && !r_inrange;
            werr     <= (|we) && !w_inrange;
        end
    end

    if (OUT_REG == 0) begin : g_direct
        always_ff @(posedge clk or posedge rst) begin
            if (rst)     s1_data <= '0;
            else if (re) s1_data <= rd_word;
        end

        assign rdo    = s1_data;
        assign rvalid = s1_valid;
        assign rerr   = s1_err;
    end else begin : g_piped
        logic [BIT_WIDTH-1:0] s2_data;
        logic                 s2_valid;
        logic                 s2_err;

        // Unreset so it can live in the RAM's own output latch; s1_valid guards its use.
        always_ff @(posedge clk) begin
            if (re) s1_data <= rd_word;
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                s2_data  <= '0;
                s2_valid <= 1'b0;
                s2_err   <= 1'b0;
            end else begin
                s2_valid <= s1_valid;
                s2_err   <= s1_err;
                if (s1_valid) s2_data <= s1_data;
            end
        end

        assign rdo    = s2_data;
        assign rvalid = s2_valid;
        assign rerr   = s2_err;
    end

endmodule

// File: tb/tb_bram_dp_be.sv
// Directed bench for bram_dp_be: read-first, write-first and output-registered instances
// share one stimulus stream; each is compared against hand-computed expectations.
module tb_bram_dp_be;

    localparam int AW = 12;
    localparam int BW = 32;
    localparam int NB = BW / 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [NB-1:0] we;
    logic [AW-1:0] waddr;
    logic [BW-1:0] wdi;
    logic          re;
    logic [AW-1:0] raddr;

    logic [BW-1:0] rdo0, rdo1, rdo2;
    logic          rvalid0, rvalid1, rvalid2;
    logic          werr0, werr1, werr2;
    logic          rerr0, rerr1, rerr2;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    bram_dp_be #(.ADDR_WIDTH(AW), .DEPTH(11), .BIT_WIDTH(BW), .OUT_REG(0), .RDW_MODE(0)) u_rf (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdi(wdi), .re(re), .raddr(raddr),
        .rdo(rdo0), .rvalid(rvalid0), .werr(werr0), .rerr(rerr0));

    bram_dp_be #(.ADDR_WIDTH(AW), .DEPTH(11), .BIT_WIDTH(BW), .OUT_REG(0), .RDW_MODE(1)) u_wf (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdi(wdi), .re(re), .raddr(raddr),
        .rdo(rdo1), .rvalid(rvalid1), .werr(werr1), .rerr(rerr1));

    bram_dp_be #(.ADDR_WIDTH(AW), .DEPTH(11), .BIT_WIDTH(BW), .OUT_REG(1), .RDW_MODE(0)) u_or (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdi(wdi), .re(re), .raddr(raddr),
        .rdo(rdo2), .rvalid(rvalid2), .werr(werr2), .rerr(rerr2));

    typedef struct {
        logic [NB-1:0] we;
        logic [AW-1:0] waddr;
        logic [BW-1:0] wdi;
        logic          re;
        logic [AW-1:0] raddr;
        logic [BW-1:0] e_rdo_rf;
        logic [BW-1:0] e_rdo_wf;
        logic          e_werr;
        logic          e_rerr;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Idle-read entries inherit the held rdo of the previous entry.
    task automatic add(input logic [NB-1:0] w, input int wa, input logic [BW-1:0] d,
                       input logic r, input int ra, input logic [BW-1:0] rf,
                       input logic [BW-1:0] wf, input logic e_we, input logic e_re);
        vec_t v;
        v.we = w; v.waddr = AW'(wa); v.wdi = d; v.re = r; v.raddr = AW'(ra);
        v.e_werr = e_we; v.e_rerr = e_re;
        if (r) begin
            v.e_rdo_rf = rf; v.e_rdo_wf = wf;
        end else if (vecs.size() == 0) begin
            v.e_rdo_rf = '0; v.e_rdo_wf = '0;
        end else begin
            v.e_rdo_rf = vecs[vecs.size()-1].e_rdo_rf;
            v.e_rdo_wf = vecs[vecs.size()-1].e_rdo_wf;
        end
        vecs.push_back(v);
    endtask

    task automatic drive(input logic [NB-1:0] w, input int wa, input logic [BW-1:0] d,
                         input logic r, input int ra);
        we = w; waddr = AW'(wa); wdi = d; re = r; raddr = AW'(ra);
    endtask

    logic [BW-1:0] prev_rdo;
    logic          prev_rvalid;
    logic          prev_rerr;

    initial begin
        // Fill every word, then read all back-to-back.
        for (int k = 0; k < 11; k++) add(4'hF, k, 32'(k) * 32'h1111_1111, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 11; k++)
            add(4'h0, 0, 0, 1, k, 32'(k) * 32'h1111_1111, 32'(k) * 32'h1111_1111, 0, 0);
        // Byte enables.
        add(4'hF, 3, 32'hAABB_CCDD, 0, 0, 0, 0, 0, 0);
        add(4'h5, 3, 32'h1122_3344, 0, 0, 0, 0, 0, 0);
        add(4'h0, 0, 0, 1, 3, 32'hAA22_CC44, 32'hAA22_CC44, 0, 0);
        // Full-word collision.
        add(4'hF, 5, 32'h1234_5678, 0, 0, 0, 0, 0, 0);
        add(4'hF, 5, 32'hCAFE_F00D, 1, 5, 32'h1234_5678, 32'hCAFE_F00D, 0, 0);
        add(4'h0, 0, 0, 1, 5, 32'hCAFE_F00D, 32'hCAFE_F00D, 0, 0);
        // Partial-byte collision on addr 7 (holds 0x77777777).
        add(4'h9, 7, 32'hA1B2_C3D4, 1, 7, 32'h7777_7777, 32'hA177_77D4, 0, 0);
        add(4'h0, 0, 0, 1, 7, 32'hA177_77D4, 32'hA177_77D4, 0, 0);
        // Out-of-range write, disabled out-of-range write, out-of-range read.
        add(4'hF, 11, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 0);
        add(4'h0, 12, 32'hDEAD_BEEF, 0, 0, 0, 0, 1, 0);
        add(4'h0, 0, 0, 1, 11, 32'h0, 32'h0, 0, 0);
        add(4'h0, 0, 0, 0, 0, 0, 0, 0, 1);
        // Independent read and write on different addresses.
        add(4'hF, 6, 32'h6666_0000, 1, 4, 32'h4444_4444, 32'h4444_4444, 0, 0);
        add(4'h0, 0, 0, 1, 6, 32'h6666_0000, 32'h6666_0000, 0, 0);
        add(4'h0, 0, 0, 1, 10, 32'hAAAA_AAAA, 32'hAAAA_AAAA, 0, 0);
        add(4'h0, 0, 0, 1, 0, 32'h0, 32'h0, 0, 0);
        add(4'h0, 0, 0, 1, 3, 32'hAA22_CC44, 32'hAA22_CC44, 0, 0);
        add(4'h0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(4'h0, 0, 0, 0, 0, 0, 0, 0, 0);

        // The werr/rerr flags were entered against the entry after the cause; shift them back.
        for (int i = 0; i < vecs.size() - 1; i++) begin
            vecs[i].e_werr = vecs[i+1].e_werr;
            vecs[i].e_rerr = vecs[i+1].e_rerr;
        end
        vecs[vecs.size()-1].e_werr = 1'b0;
        vecs[vecs.size()-1].e_rerr = 1'b0;

        rst = 1'b1;
        drive(4'h0, 0, 0, 0, 0);
        #1;
        check("reset u_rf.rdo", rdo0, 32'h0);
        check("reset u_rf.rvalid", 32'(rvalid0), 32'h0);
        check("reset u_rf.werr", 32'(werr0), 32'h0);
        check("reset u_rf.rerr", 32'(rerr0), 32'h0);
        check("reset u_wf.rdo", rdo1, 32'h0);
        check("reset u_or.rdo", rdo2, 32'h0);
        check("reset u_or.rvalid", 32'(rvalid2), 32'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        prev_rdo = '0; prev_rvalid = 1'b0; prev_rerr = 1'b0;
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].we, int'(vecs[i].waddr), vecs[i].wdi, vecs[i].re, int'(vecs[i].raddr));
            @(posedge clk);
            #1;
            check($sformatf("v%0d u_rf.rdo", i), rdo0, vecs[i].e_rdo_rf);
            check($sformatf("v%0d u_rf.rvalid", i), 32'(rvalid0), 32'(vecs[i].re));
            check($sformatf("v%0d u_rf.werr", i), 32'(werr0), 32'(vecs[i].e_werr));
            check($sformatf("v%0d u_rf.rerr", i), 32'(rerr0), 32'(vecs[i].e_rerr));
            check($sformatf("v%0d u_wf.rdo", i), rdo1, vecs[i].e_rdo_wf);
            check($sformatf("v%0d u_wf.rvalid", i), 32'(rvalid1), 32'(vecs[i].re));
            check($sformatf("v%0d u_or.rdo", i), rdo2, prev_rdo);
            check($sformatf("v%0d u_or.rvalid", i), 32'(rvalid2), 32'(prev_rvalid));
            check($sformatf("v%0d u_or.rerr", i), 32'(rerr2), 32'(prev_rerr));
            check($sformatf("v%0d u_or.werr", i), 32'(werr2), 32'(vecs[i].e_werr));
            prev_rdo    = vecs[i].e_rdo_rf;
            prev_rvalid = vecs[i].re;
            prev_rerr   = vecs[i].e_rerr;
        end

        // Reset while a read is in flight in the registered-output instance.
        drive(4'h0, 0, 0, 1, 1);
        @(posedge clk);
        #1;
        check("rstmid u_rf.rdo before", rdo0, 32'h1111_1111);
        check("rstmid u_or.rvalid before", 32'(rvalid2), 32'h0);
        drive(4'h0, 0, 0, 0, 0);
        rst = 1'b1;
        #1;
        check("rstmid u_rf.rdo async", rdo0, 32'h0);
        check("rstmid u_rf.rvalid async", 32'(rvalid0), 32'h0);
        check("rstmid u_or.rdo async", rdo2, 32'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            check($sformatf("postrst%0d u_or.rvalid", c), 32'(rvalid2), 32'h0);
            check($sformatf("postrst%0d u_rf.rvalid", c), 32'(rvalid0), 32'h0);
            check($sformatf("postrst%0d u_or.rdo", c), rdo2, 32'h0);
        end
        drive(4'h0, 0, 0, 1, 3);
        @(posedge clk);
        #1;
        drive(4'h0, 0, 0, 0, 0);
        check("postrst read u_rf.rdo", rdo0, 32'hAA22_CC44);
        check("postrst read u_rf.rvalid", 32'(rvalid0), 32'h1);
        check("postrst read u_or.rvalid early", 32'(rvalid2), 32'h0);
        @(posedge clk);
        #1;
        check("postrst read u_or.rdo", rdo2, 32'hAA22_CC44);
        check("postrst read u_or.rvalid", 32'(rvalid2), 32'h1);
        check("postrst read u_rf.rvalid idle", 32'(rvalid0), 32'h0);
        check("postrst read u_rf.rdo hold", rdo0, 32'hAA22_CC44);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
